// File: rtl/shared_mem_rr_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between NCORE cores.
//
// Handshake: a core raises req[i] with rd/wr/addr/wdata and holds req until it
// sees ack[i]. Those fields are latched when the core wins arbitration in IDLE,
// so they may change freely once gnt[i] is seen. ack[i] is a one-cycle pulse,
// and rdata is valid while ack is high. If req stays high after ack, that is a
// new request.
//
// Each transaction walks IDLE -> ACCESS -> WAIT (MEM_LAT cycles, skipped when
// MEM_LAT==0) -> RESP -> IDLE. All outputs are registered. state_q is the
// FSM state register that checkers can bind to.
module shared_mem_rr_arbiter #(
  parameter int NCORE   = 4,
  parameter int IDW     = 2,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCORE-1:0]      req,
  input  logic [NCORE-1:0]      rd,
  input  logic [NCORE-1:0]      wr,
  input  logic [NCORE*32-1:0]   addr,
  input  logic [NCORE*32-1:0]   wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [NCORE-1:0]      gnt,
  output logic [NCORE-1:0]      ack,
  output logic [31:0]           rdata,
  output logic                  busy,
  output logic [IDW-1:0]        owner,
  output logic [31:0]           xfer_cnt
);

  localparam int CW = IDW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     owner_q;
  logic [3:0]         wcnt_q;
  logic               op_rd_q;
  logic [NCORE-1:0]   gnt_q;
  logic [NCORE-1:0]   ack_q;
  logic               mem_rd_q;
  logic               mem_wr_q;
  logic [31:0]        mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic [31:0]        rdata_q;
  logic               busy_q;
  logic [31:0]        xfer_cnt_q;

  // Arbitration result and the winner's request fields.
  logic               found_d;
  logic [IDW-1:0]     owner_d;
  logic [NCORE-1:0]   win_oh_d;
  logic [31:0]        sel_addr_d;
  logic [31:0]        sel_wdata_d;
  logic               sel_rd_d;
  logic               sel_wr_d;
  logic [CW-1:0]      scan_sum;
  logic [IDW-1:0]     scan_cand;
  logic               scan_hit;
  logic [IDW-1:0]     ptr_next;

  // Scan upward from ptr_q, wrapping modulo NCORE; the first requester wins.
  always_comb begin
    found_d   = 1'b0;
    owner_d   = '0;
    scan_sum  = '0;
    scan_cand = '0;
    scan_hit  = 1'b0;
    for (int k = 0; k < NCORE; k++) begin
      scan_sum = {1'b0, ptr_q} + CW'(k);
      if (scan_sum >= CW'(NCORE)) scan_sum = scan_sum - CW'(NCORE);
      scan_cand = scan_sum[IDW-1:0];
      scan_hit  = 1'b0;
      for (int j = 0; j < NCORE; j++) begin
        if (scan_cand == IDW'(j)) scan_hit = req[j];
      end
      if (!found_d && scan_hit) begin
        found_d = 1'b1;
        owner_d = scan_cand;
      end
    end
  end

  // Mux out the winning core's fields and build its one-hot grant.
  always_comb begin
    win_oh_d    = '0;
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    sel_rd_d    = 1'b0;
    sel_wr_d    = 1'b0;
    for (int j = 0; j < NCORE; j++) begin
      if (owner_d == IDW'(j)) begin
        win_oh_d[j] = 1'b1;
        sel_addr_d  = addr[j*32 +: 32];
        sel_wdata_d = wdata[j*32 +: 32];
        sel_rd_d    = rd[j];
        sel_wr_d    = wr[j];
      end
    end
  end

  // After serving owner_q, the next core up gets first priority.
  always_comb begin
    ptr_next = (owner_q == IDW'(NCORE-1)) ? '0 : owner_q + IDW'(1);
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      wcnt_q      <= '0;
      op_rd_q     <= 1'b0;
      gnt_q       <= '0;
      ack_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            state_q     <= S_ACCESS;
            owner_q     <= owner_d;
            gnt_q       <= win_oh_d;
            busy_q      <= 1'b1;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            // A write takes precedence when both qualifiers are set.
            mem_wr_q    <= sel_wr_d;
            mem_rd_q    <= sel_rd_d & ~sel_wr_d;
            op_rd_q     <= sel_rd_d & ~sel_wr_d;
          end
        end
        S_ACCESS: begin
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          wcnt_q   <= 4'(MEM_LAT);
          if (MEM_LAT == 0) begin
            if (op_rd_q) rdata_q <= mem_rdata;
            ack_q   <= gnt_q;
            state_q <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Writes and no-ops wait too, so every transaction has the same latency.
          if (wcnt_q == 4'd1) begin
            if (op_rd_q) rdata_q <= mem_rdata;
            ack_q   <= gnt_q;
            state_q <= S_RESP;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        S_RESP: begin
          ack_q      <= '0;
          gnt_q      <= '0;
          busy_q     <= 1'b0;
          xfer_cnt_q <= xfer_cnt_q + 32'd1;
          ptr_q      <= ptr_next;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_shared_mem_rr_arbiter.sv
// Bench for shared_mem_rr_arbiter: directed scenarios, then randomized core
// traffic, all checked every cycle against a transaction-level model. A second
// instance built with MEM_LAT=0 covers the zero-latency path.
module tb_shared_mem_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int L   = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- main DUT (MEM_LAT = 1) ----------------
  logic [N-1:0]    req, rd, wr;
  logic [N*32-1:0] addr, wdata;
  logic [31:0]     mem_rdata;
  logic            mem_rd, mem_wr, busy;
  logic [31:0]     mem_addr, mem_wdata, rdata, xfer_cnt;
  logic [N-1:0]    gnt, ack;
  logic [IDW-1:0]  owner;

  shared_mem_rr_arbiter #(.NCORE(N), .IDW(IDW), .MEM_LAT(L)) dut (
    .clk(clk), .reset(reset), .req(req), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .gnt(gnt), .ack(ack),
    .rdata(rdata), .busy(busy), .owner(owner), .xfer_cnt(xfer_cnt)
  );

  // ---------------- second DUT (MEM_LAT = 0) ----------------
  logic [N-1:0]    req0, rd0, wr0;
  logic [N*32-1:0] addr0, wdata0;
  logic [31:0]     mem_rdata0;
  logic            mem_rd0, mem_wr0, busy0;
  logic [31:0]     mem_addr0, mem_wdata0, rdata0, xfer_cnt0;
  logic [N-1:0]    gnt0, ack0;
  logic [IDW-1:0]  owner0;

  shared_mem_rr_arbiter #(.NCORE(N), .IDW(IDW), .MEM_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .rd(rd0), .wr(wr0), .addr(addr0),
    .wdata(wdata0), .mem_rdata(mem_rdata0), .mem_rd(mem_rd0), .mem_wr(mem_wr0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .gnt(gnt0), .ack(ack0),
    .rdata(rdata0), .busy(busy0), .owner(owner0), .xfer_cnt(xfer_cnt0)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- memory responder (returns the address as data) --------
  // Read data appears one cycle after the strobe; otherwise the bus carries noise.
  initial begin
    logic        s;
    logic [31:0] a;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      s = mem_rd;
      a = mem_addr;
      @(posedge clk);
      #1;
      mem_rdata = s ? a : $urandom;
    end
  end

  // ---------------- behavioural model ----------------
  // m_pos: -1 when idle, otherwise cycles since the grant was issued
  // (0 = strobe cycle, L+1 = acknowledge cycle).
  int          m_pos = -1;
  int          m_own = 0;
  int          m_ptr = 0;
  int          m_c;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0, m_cnt = '0;
  logic        m_rd = 1'b0, m_wr = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_pos = -1; m_own = 0; m_ptr = 0; m_rdata = '0; m_cnt = '0;
    end else if (m_pos < 0) begin
      for (int k = 0; k < N; k++) begin
        m_c = (m_ptr + k) % N;
        if (m_pos < 0 && req[m_c]) begin
          m_own   = m_c;
          m_addr  = addr[m_c*32 +: 32];
          m_wdata = wdata[m_c*32 +: 32];
          m_rd    = rd[m_c];
          m_wr    = wr[m_c];
          m_pos   = 0;
        end
      end
    end else if (m_pos == L + 1) begin
      m_cnt = m_cnt + 32'd1;
      m_ptr = (m_own + 1) % N;
      m_pos = -1;
    end else begin
      m_pos++;
      if (m_pos == L + 1 && m_rd && !m_wr) m_rdata = m_addr;
    end
  end

  // ---------------- per-cycle compare + fairness ----------------
  int n_wr = 0, n_rd = 0, n_ack3 = 0;
  int wait_n[N];
  initial for (int i = 0; i < N; i++) wait_n[i] = 0;

  always @(negedge clk) begin
    logic [N-1:0] e_gnt, e_ack;
    e_gnt = (m_pos >= 0) ? oh(m_own) : '0;
    e_ack = (m_pos == L + 1) ? oh(m_own) : '0;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(m_pos >= 0));
    chk("mem_wr", 32'(mem_wr), 32'(m_pos == 0 && m_wr));
    chk("mem_rd", 32'(mem_rd), 32'(m_pos == 0 && m_rd && !m_wr));
    if (m_pos == 0 && (m_rd || m_wr)) chk("mem_addr", mem_addr, m_addr);
    if (m_pos == 0 && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    chk("rdata", rdata, m_rdata);
    chk("owner", 32'(owner), 32'(m_own));
    chk("xfer_cnt", xfer_cnt, m_cnt);
    if (mem_wr) n_wr++;
    if (mem_rd) n_rd++;
    if (ack[3]) n_ack3++;
    // A waiting requester sees at most N-1 other completions before its own.
    for (int i = 0; i < N; i++) begin
      if (!reset) wait_n[i] = 0;
      else if (ack[i]) begin
        chk("fairness", 32'(wait_n[i] <= N - 1), 32'd1);
        wait_n[i] = 0;
      end else if (!req[i]) wait_n[i] = 0;
      else if (ack != '0) wait_n[i]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    rd[i] = r;
    wr[i] = w;
    addr[i*32 +: 32]  = a;
    wdata[i*32 +: 32] = d;
  endtask

  task automatic new_req(input int i);
    req[i] = 1'b1;
    set_core(i, rbit(), rbit(), $urandom & 32'hFFFF_FFFC, $urandom);
  endtask

  task automatic wait_ack(input int i, input int max, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      tick();
      cyc++;
      if (ack[i]) ok = 1'b1;
    end
  endtask

  task automatic wait_gnt(input int i, input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      tick();
      if (gnt[i]) ok = 1'b1;
    end
  endtask

  task automatic wait_any_ack(input int max, output logic [N-1:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int k = 0; k < max && !ok; k++) begin
      tick();
      if (ack != '0) begin ok = 1'b1; a = ack; end
    end
  endtask

  task automatic drain(input int max);
    bit quiet;
    quiet = 1'b0;
    for (int k = 0; k < max && !quiet; k++) begin
      tick();
      for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
      if (req == '0 && !busy) quiet = 1'b1;
    end
    chk("drain_timeout", 32'(quiet), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc, nw, nr, na3;
    bit ok;
    logic [N-1:0] a;

    req0 = '0; rd0 = '0; wr0 = '0; addr0 = '0; wdata0 = '0; mem_rdata0 = '0;

    // Reset with random inputs: everything must come up zero.
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      req = N'($urandom); rd = N'($urandom); wr = N'($urandom);
      for (int i = 0; i < N; i++) set_core(i, rbit(), rbit(), $urandom, $urandom);
      tick();
    end
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_xfer_cnt", xfer_cnt, 32'd0);

    // Single write by core 0.
    req = '0; rd = '0; wr = '0; addr = '0; wdata = '0;
    reset = 1'b1;
    set_core(0, 1'b0, 1'b1, 32'h10, 32'h145);
    req = 4'b0001;
    nw = n_wr; nr = n_rd;
    wait_ack(0, 10, cyc, ok);
    chk("t1_ack_seen", 32'(ok), 32'd1);
    chk("t1_latency", 32'(cyc), 32'd3);
    chk("t1_wr_pulses", 32'(n_wr - nw), 32'd1);
    chk("t1_rd_pulses", 32'(n_rd - nr), 32'd0);
    req = '0;
    tick();
    chk("t1_xfer_cnt", xfer_cnt, 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // All four cores reading continuously: strict rotation from core 0.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 32'h100 + 32'(4 * i), $urandom);
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      wait_any_ack(10, a, ok);
      chk("t2_ack_seen", 32'(ok), 32'd1);
      exp_q.push_back(32'(oh(t % N)));
      chk("t2_order", 32'(a), exp_q.pop_front());
      chk("t2_rdata", rdata, 32'h100 + 32'(4 * (t % N)));
    end
    req = '0;
    tick();

    // Core 2 with both rd and wr: only the write strobe fires.
    set_core(2, 1'b1, 1'b1, 32'h20, 32'h77);
    req = 4'b0100;
    nw = n_wr; nr = n_rd;
    wait_ack(2, 10, cyc, ok);
    chk("t3_ack_seen", 32'(ok), 32'd1);
    chk("t3_wr_pulses", 32'(n_wr - nw), 32'd1);
    chk("t3_rd_pulses", 32'(n_rd - nr), 32'd0);
    req = '0;
    tick();

    // Core 1 drops req while granted; the next arbitration starts at core 2.
    set_core(1, 1'b1, 1'b0, 32'h40, 32'h0);
    req = 4'b0010;
    wait_gnt(1, 10, ok);
    chk("t4_gnt1_seen", 32'(ok), 32'd1);
    tick();
    req[1] = 1'b0;
    set_core(0, 1'b1, 1'b0, 32'h50, 32'h0);
    set_core(2, 1'b1, 1'b0, 32'h54, 32'h0);
    set_core(3, 1'b1, 1'b0, 32'h60, 32'h0);
    req[0] = 1'b1; req[2] = 1'b1; req[3] = 1'b1;
    wait_ack(1, 10, cyc, ok);
    chk("t4_ack1_seen", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int k = 0; k < 6 && !ok; k++) begin
      tick();
      if (gnt != '0) ok = 1'b1;
    end
    chk("t4_next_winner", 32'(gnt), 32'(4'b0100));
    drain(40);

    // Reset during core 3's wait phase aborts the transaction.
    set_core(3, 1'b1, 1'b0, 32'h70, 32'h0);
    req = 4'b1000;
    na3 = n_ack3;
    wait_gnt(3, 10, ok);
    chk("t5_gnt3_seen", 32'(ok), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_xfer_cnt", xfer_cnt, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    req = '0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("t5_no_ack3", 32'(n_ack3 - na3), 32'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = ($urandom_range(0, 999) != 0);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else new_req(i);
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
          else set_core(i, rbit(), rbit(), $urandom, $urandom);
        end else if (gnt[i]) begin
          set_core(i, rbit(), rbit(), $urandom, $urandom);
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end
      end
    end
    reset = 1'b1;
    drain(60);

    // Zero-latency instance: single read by core 0.
    rd0[0] = 1'b1;
    addr0[31:0] = 32'h30;
    mem_rdata0 = 32'h1111_1111;
    req0 = 4'b0001;
    tick();
    chk("z_gnt", 32'(gnt0), 32'(4'b0001));
    chk("z_mem_rd", 32'(mem_rd0), 32'd1);
    chk("z_mem_addr", mem_addr0, 32'h30);
    chk("z_ack_early", 32'(ack0), 32'd0);
    mem_rdata0 = 32'hDEAD_BEEF;
    tick();
    chk("z_ack", 32'(ack0), 32'(4'b0001));
    chk("z_rdata", rdata0, 32'hDEAD_BEEF);
    mem_rdata0 = 32'h5555_5555;
    req0 = '0;
    tick();
    chk("z_ack_done", 32'(ack0), 32'd0);
    chk("z_xfer_cnt", xfer_cnt0, 32'd1);
    chk("z_rdata_hold", rdata0, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
